// File: rtl/alu_result_bcd_pkg.sv
// Shared definitions for the ALU result binary-to-BCD converter:
// FSM state encoding, BCD nibble width and a counter-width helper.
package alu_result_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int BCD_W = 4;

  // Bits needed to hold values 0 .. value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_result_bcd_add3.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import alu_result_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/alu_result_bcd.sv
// Sequential binary-to-BCD converter sitting behind the calculator ALU.
// Accepts a 2*WIDTH-bit result over valid/ready, runs one double-dabble
// shift per clock, and holds DIGITS packed BCD digits until the display
// stage takes them.
// Optional feature: define SIGNED_RESULT_EN to treat bin_i as two's
// complement (magnitude is converted, neg_o flags negative results).
// Without it bin_i is unsigned and neg_o is tied to 0.
module alu_result_bcd
  import alu_result_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [2*WIDTH-1:0]        bin_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [BCD_W*DIGITS-1:0]   bcd_o,
  output logic                      neg_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam int BIN_W   = 2 * WIDTH;
  localparam int BCD_TOT = BCD_W * DIGITS;
  localparam int WORK_W  = BCD_TOT + BIN_W;
  localparam int CNT_W   = clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  state_e               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIN_W-1:0]     bin_sr;
  logic [BCD_TOT-1:0]   bcd_sr;
  logic [BCD_TOT-1:0]   bcd_adj;
  logic [WORK_W-1:0]    work;
  logic [WORK_W-1:0]    work_shift;
  logic [BIN_W-1:0]     mag;

  assign ready_o = (state == ST_IDLE);

`ifdef SIGNED_RESULT_EN
  logic signed [BIN_W-1:0] bin_s;
  logic                    load_neg;
  logic                    neg_r;

  // Negative inputs are converted as their magnitude; the most negative
  // value wraps onto itself, which is exactly its unsigned magnitude.
  assign bin_s    = bin_i;
  assign load_neg = (bin_s < 0);
  assign mag      = load_neg ? $unsigned(-bin_s) : bin_i;
`else
  assign mag   = bin_i;
  assign neg_o = 1'b0;
`endif

  // One correction cell per BCD digit, applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (bcd_sr[g*BCD_W +: BCD_W]),
      .q (bcd_adj[g*BCD_W +: BCD_W])
    );
  end

  // BCD digits and remaining binary bits shift as one word so the binary
  // MSB falls into the units digit.
  assign work       = {bcd_adj, bin_sr};
  assign work_shift = work << 1;

  // Control FSM, shift register, counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bcd_o   <= '0;
      valid_o <= 1'b0;
`ifdef SIGNED_RESULT_EN
      neg_r   <= 1'b0;
      neg_o   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            bin_sr <= mag;
            bcd_sr <= '0;
            cnt    <= '0;
`ifdef SIGNED_RESULT_EN
            neg_r  <= load_neg;
`endif
            state  <= ST_CONV;
          end
        end
        ST_CONV: begin
          bcd_sr <= work_shift[WORK_W-1:BIN_W];
          bin_sr <= work_shift[BIN_W-1:0];
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_SHIFT) begin
            bcd_o   <= work_shift[WORK_W-1:BIN_W];
`ifdef SIGNED_RESULT_EN
            neg_o   <= neg_r;
`endif
            valid_o <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_bcd.sv
// Randomized scoreboard bench for alu_result_bcd (WIDTH=8, DIGITS=5).
// The driver pushes the decimal expectation of each accepted word; a
// monitor pops and compares whenever valid_o rises.
module tb_alu_result_bcd;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 5;
  localparam int BW     = 2 * WIDTH;
  localparam int LAT    = 2 * WIDTH;

`ifdef SIGNED_RESULT_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BW-1:0]     bin;
  logic              valid_in;
  logic              ready_out;
  logic [4*DIGITS-1:0] bcd;
  logic              neg;
  logic              valid_out;
  logic              ready_in;

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    logic                neg;
    int                  e0;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bin_i   (bin),
    .valid_i (valid_in),
    .ready_o (ready_out),
    .bcd_o   (bcd),
    .neg_o   (neg),
    .valid_o (valid_out),
    .ready_i (ready_in)
  );

  // Reference: decimal digits of the (signed or unsigned) value.
  function automatic exp_t model(input logic [BW-1:0] b, input int e0);
    exp_t r;
    int   v;
    v     = int'(b);
    r.neg = 1'b0;
    if (SIGNED_MODE && b[BW-1]) begin
      r.neg = 1'b1;
      v     = (1 << BW) - v;
    end
    r.bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r.bcd[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    r.e0 = e0;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on every rising valid_out.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (valid_out && !prev) begin
        if (q.size() == 0) begin
          check("spurious_valid", 32'(valid_out), 32'd0);
        end else begin
          e = q.pop_front();
          check("bcd", 32'(bcd), 32'(e.bcd));
          check("neg", 32'(neg), 32'(e.neg));
          check("latency", 32'(cyc - e.e0), 32'(LAT));
        end
      end
      prev = valid_out;
    end
  end

  // Present one word and record its expectation at the accepting edge.
  task automatic send(input logic [BW-1:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready_out && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready_out) check("ready_timeout", 32'(ready_out), 32'd1);
    valid_in = 1'b1;
    bin      = b;
    @(posedge clk);
    #1;
    q.push_back(model(b, cyc));
    valid_in = 1'b0;
    bin      = BW'($urandom);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!valid_out && t < 60);
    if (!valid_out) check("valid_timeout", 32'(valid_out), 32'd1);
  endtask

  // Full transaction with 'hold' cycles of back-pressure before accepting.
  task automatic conv(input logic [BW-1:0] b, input int hold);
    ready_in = 1'b0;
    send(b);
    wait_valid();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(valid_out), 32'd1);
      check("hold_ready_o", 32'(ready_out), 32'd0);
    end
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    ready_in = 1'b0;
    check("done_exit_valid", 32'(valid_out), 32'd0);
    check("done_exit_ready", 32'(ready_out), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] r;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    bin      = '0;
    #2;
    check("rst_ready_o", 32'(ready_out), 32'd1);
    check("rst_valid_o", 32'(valid_out), 32'd0);
    check("rst_bcd_o",   32'(bcd),       32'd0);
    check("rst_neg_o",   32'(neg),       32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values with literal expectations (held after handshake).
    conv(16'd20, 0);
    check("lit_20", 32'(bcd), 32'h00020);
    check("lit_20_neg", 32'(neg), 32'd0);
    conv(16'hFFFF, 2);
`ifdef SIGNED_RESULT_EN
    check("lit_ffff", 32'(bcd), 32'h00001);
    check("lit_ffff_neg", 32'(neg), 32'd1);
`else
    check("lit_ffff", 32'(bcd), 32'h65535);
    check("lit_ffff_neg", 32'(neg), 32'd0);
`endif
    conv(16'd0, 1);
    check("lit_0", 32'(bcd), 32'h00000);
    conv(16'hFFF6, 0);
`ifdef SIGNED_RESULT_EN
    check("lit_fff6", 32'(bcd), 32'h00010);
    check("lit_fff6_neg", 32'(neg), 32'd1);
`else
    check("lit_fff6", 32'(bcd), 32'h65526);
    check("lit_fff6_neg", 32'(neg), 32'd0);
`endif
    conv(16'h8000, 0);
    check("lit_8000", 32'(bcd), 32'h32768);
    check("lit_8000_neg", 32'(neg), SIGNED_MODE ? 32'd1 : 32'd0);

    // Back-pressure: 10 cycles held, valid_in pulse in DONE ignored.
    ready_in = 1'b0;
    send(16'd6);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(valid_out), 32'd1);
      check("bp_bcd", 32'(bcd), 32'h00006);
      check("bp_ready_o", 32'(ready_out), 32'd0);
      if (i == 4) begin
        valid_in = 1'b1;
        bin      = 16'd999;
      end
      if (i == 5) valid_in = 1'b0;
    end
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    ready_in = 1'b0;
    check("bp_exit_valid", 32'(valid_out), 32'd0);
    check("bp_exit_ready", 32'(ready_out), 32'd1);
    check("bp_bcd_kept", 32'(bcd), 32'h00006);

    // ready_in high throughout: DONE lasts one cycle.
    ready_in = 1'b1;
    send(16'd4711);
    wait_valid();
    @(posedge clk);
    #1;
    check("cont_valid_1cyc", 32'(valid_out), 32'd0);
    check("cont_ready_o", 32'(ready_out), 32'd1);
    ready_in = 1'b0;

    // Reset at cnt=7: partial result discarded.
    send(16'h4321);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("mid_rst_bcd", 32'(bcd), 32'd0);
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    check("mid_rst_ready", 32'(ready_out), 32'd1);
    check("mid_rst_neg", 32'(neg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    conv(16'd1234, 0);
    check("lit_1234", 32'(bcd), 32'h01234);

    // Random traffic with random back-pressure.
    for (int n = 0; n < 40; n++) begin
      r = BW'($urandom);
      conv(r, int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
